gf2m_trinomial_reducer: RTL and testbench



---
 rtl/gf2m_pkg.sv | 23 ++
 rtl/gf2m_fold_step.sv | 34 +++
 rtl/gf2m_trinomial_reducer.sv | 118 +++++++++++
 tb/tb_gf2m_trinomial_reducer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gf2m_pkg.sv
// Shared constants, state encoding and digit-count helper for the GF(2^233)
// trinomial reducer (f(x) = x^233 + x^74 + 1).
package gf2m_pkg;

  localparam int M      = 233;
  localparam int K      = 74;
  localparam int PROD_W = 2 * M;
  localparam int DIGIT_DEF = 8;

  function automatic int n_digits(input int prod_w, input int m, input int digit);
    return (prod_w - m + digit - 1) / digit;
  endfunction

  localparam int N_DEF     = n_digits(PROD_W, M, DIGIT_DEF);
  localparam int CNT_W_DEF = $clog2(N_DEF + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/gf2m_fold_step.sv
// One digit of trinomial reduction: clears R[hi:lo] and folds it back in at
// offsets lo-M+K and lo-M (x^M == x^K + 1).
module gf2m_fold_step #(
  parameter int M      = gf2m_pkg::M,
  parameter int K      = gf2m_pkg::K,
  parameter int PROD_W = gf2m_pkg::PROD_W,
  parameter int IDX_W  = $clog2(PROD_W)
) (
  input  logic [PROD_W-1:0] r,
  input  logic [IDX_W-1:0]  hi,
  input  logic [IDX_W-1:0]  lo,
  output logic [PROD_W-1:0] r_next
);

  localparam logic [PROD_W-1:0] ONE = PROD_W'(1);

  logic [IDX_W-1:0]  width;
  logic [IDX_W-1:0]  off_k;
  logic [IDX_W-1:0]  off_0;
  logic [PROD_W-1:0] mask;
  logic [PROD_W-1:0] seg;

  // lo >= M always holds, so the offsets never wrap; the landing span sits
  // strictly below lo because M-K >= DIGIT.
  always_comb begin
    width  = hi - lo + IDX_W'(1);
    mask   = (ONE << width) - ONE;
    seg    = (r >> lo) & mask;
    off_k  = lo - IDX_W'(M) + IDX_W'(K);
    off_0  = lo - IDX_W'(M);
    r_next = (r & ~(seg << lo)) ^ (seg << off_k) ^ (seg << off_0);
  end

endmodule

// File: rtl/gf2m_trinomial_reducer.sv
// Digit-serial reducer of a 466-bit GF(2)[x] product modulo x^M + x^K + 1.
// Optional deg_err output when GF2M_REDUCER_DEGCHK_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a product, in_ready=1
// REDUCE | folding one digit per cycle, top degree downward
// DONE   | result presented on res with out_valid=1 until out_ready
module gf2m_trinomial_reducer #(
  parameter int M      = gf2m_pkg::M,
  parameter int K      = gf2m_pkg::K,
  parameter int DIGIT  = gf2m_pkg::DIGIT_DEF,
  parameter int PROD_W = 2 * M
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M-1:0]      res
`ifdef GF2M_REDUCER_DEGCHK_EN
  ,
  output logic              deg_err
`endif
);

  import gf2m_pkg::*;

  localparam int N     = n_digits(PROD_W, M, DIGIT);
  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = $clog2(PROD_W);

  state_t            state;
  state_t            state_nxt;
  logic [PROD_W-1:0] r;
  logic [PROD_W-1:0] r_next;
  logic [CNT_W-1:0]  cnt;
  logic              last_step;
  int                hi_i;
  int                lo_i;
  logic [IDX_W-1:0]  hi;
  logic [IDX_W-1:0]  lo;

  assign last_step = (cnt == CNT_W'(N - 1));

  always_comb begin
    hi_i = PROD_W - 1 - int'(cnt) * DIGIT;
    lo_i = hi_i - DIGIT + 1;
    if (lo_i < M) lo_i = M;
    hi = IDX_W'(hi_i);
    lo = IDX_W'(lo_i);
  end

  gf2m_fold_step #(
    .M      (M),
    .K      (K),
    .PROD_W (PROD_W),
    .IDX_W  (IDX_W)
  ) u_fold (
    .r      (r),
    .hi     (hi),
    .lo     (lo),
    .r_next (r_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = REDUCE;
      REDUCE:  if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r   <= '0;
      cnt <= '0;
      res <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r   <= prod;
            cnt <= '0;
          end
        end
        REDUCE: begin
          r   <= r_next;
          cnt <= cnt + CNT_W'(1);
          if (last_step) res <= r_next[M-1:0];
        end
        default: ;
      endcase
    end
  end

`ifdef GF2M_REDUCER_DEGCHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                deg_err <= 1'b0;
    else if (state == IDLE && in_valid)      deg_err <= prod[PROD_W-1];
    else if (state == DONE && out_ready)     deg_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_gf2m_trinomial_reducer.sv
// Directed bench for gf2m_trinomial_reducer at DIGIT = 8, 1 and 159.
module tb_gf2m_trinomial_reducer;

  localparam int PW = 466;

  logic             clk;
  logic             rst;
  logic [2:0]       iv;
  logic [2:0]       ir;
  logic [2:0]       ov;
  logic [2:0]       ordy;
  logic [PW-1:0]    prod_a [3];
  logic [232:0]     res_a  [3];
`ifdef GF2M_REDUCER_DEGCHK_EN
  logic [2:0]       deg;
`endif

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gf2m_trinomial_reducer #(
      .DIGIT (g == 0 ? 8 : (g == 1 ? 1 : 159))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .prod      (prod_a[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .res       (res_a[g])
`ifdef GF2M_REDUCER_DEGCHK_EN
      ,
      .deg_err   (deg[g])
`endif
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] bit_at(input int i);
    logic [PW-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference: clear coefficients one at a time from the top, x^i -> x^(i-M+K) + x^(i-M).
  function automatic logic [PW-1:0] model(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = p;
    for (int i = PW - 1; i >= 233; i--) begin
      if (r[i]) begin
        r[i]          = 1'b0;
        r[i - 233 + 74] = ~r[i - 233 + 74];
        r[i - 233]    = ~r[i - 233];
      end
    end
    return {233'b0, r[232:0]};
  endfunction

  task automatic run(input int idx, input logic [PW-1:0] p, input logic [PW-1:0] e, input string tag);
    int n;
    prod_a[idx] = p;
    iv[idx] = 1'b1;
    @(posedge clk); #1;
    iv[idx] = 1'b0;
    n = 0;
    while (!ov[idx] && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, PW'(ov[idx]), PW'(1));
    check(tag, PW'(res_a[idx]), e);
`ifdef GF2M_REDUCER_DEGCHK_EN
    check({tag, "_deg"}, PW'(deg[idx]), PW'(p[PW-1]));
`endif
    ordy[idx] = 1'b1;
    @(posedge clk); #1;
    ordy[idx] = 1'b0;
    check({tag, "_drop"}, PW'(ov[idx]), PW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] p;
    logic [PW-1:0] e;
    logic [232:0]  held;
    int            edges;

    rst = 1'b1;
    iv = '0;
    ordy = '0;
    for (int i = 0; i < 3; i++) prod_a[i] = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_in_ready", PW'(ir[0]), PW'(1));
    check("rst_out_valid", PW'(ov[0]), PW'(0));
    check("rst_res", PW'(res_a[0]), PW'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Latency: counting the accept edge as 1, out_valid first seen after edge 31.
    prod_a[0] = bit_at(233);
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    edges = 1;
    check("busy_in_ready", PW'(ir[0]), PW'(0));
    while (!ov[0] && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", PW'(edges), PW'(31));
    check("x233", PW'(res_a[0]), bit_at(74) | bit_at(0));
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;

    e = bit_at(231) | bit_at(146) | bit_at(72);
    run(0, bit_at(464), e, "x464_d8");
    run(1, bit_at(464), e, "x464_d1");
    run(2, bit_at(464), e, "x464_d159");
    run(1, bit_at(233), bit_at(74) | bit_at(0), "x233_d1");
    run(2, bit_at(233), bit_at(74) | bit_at(0), "x233_d159");

    run(0, PW'(16'h1234), PW'(16'h1234), "low_deg");
    run(0, '0, '0, "zero");
    run(0, bit_at(465), bit_at(232) | bit_at(147) | bit_at(73), "x465");
    run(2, bit_at(465), bit_at(232) | bit_at(147) | bit_at(73), "x465_d159");
    p = bit_at(465) | bit_at(233) | PW'(5);
    run(0, p, bit_at(232) | bit_at(147) | bit_at(74) | bit_at(73) | bit_at(2), "mixed");

    // Backpressure: hold DONE for 5 cycles while a new product is offered.
    prod_a[0] = bit_at(300);
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    edges = 0;
    while (!ov[0] && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    held = res_a[0];
    check("bp_res", PW'(held), bit_at(141) | bit_at(67));
    prod_a[0] = bit_at(233);
    iv[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_valid", PW'(ov[0]), PW'(1));
      check("bp_stable", PW'(res_a[0]), bit_at(141) | bit_at(67));
      check("bp_in_ready", PW'(ir[0]), PW'(0));
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    check("bp_release_valid", PW'(ov[0]), PW'(0));
    check("bp_release_ready", PW'(ir[0]), PW'(1));
    @(posedge clk); #1;
    iv[0] = 1'b0;
    check("bp_accepted", PW'(ir[0]), PW'(0));
    edges = 0;
    while (!ov[0] && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check("bp_next_lat", PW'(edges), PW'(30));
    check("bp_next_res", PW'(res_a[0]), bit_at(74) | bit_at(0));
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;

    // Reset in the middle of a reduction.
    prod_a[0] = bit_at(464);
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_in_ready", PW'(ir[0]), PW'(1));
    check("mid_rst_valid", PW'(ov[0]), PW'(0));
    check("mid_rst_res", PW'(res_a[0]), PW'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run(0, bit_at(233), bit_at(74) | bit_at(0), "after_rst");

    for (int t = 0; t < 6; t++) begin
      p = '0;
      for (int w = 0; w < 15; w++) p = (p << 32) | PW'($urandom);
      run(0, p, model(p), "rand_d8");
      if (t < 2) run(2, p, model(p), "rand_d159");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
